uart_receiver: RTL and testbench

Serial-to-parallel UART receiver. It is the receive-side counterpart of the team's UART transmitter and is frame-compatible with it: same DATA_BITS, stop-bit count, optional parity and parity sense. It oversamples the line using a baud-rate tick enable, recovers each frame LSB-first, and presents the byte with a one-cycle done strobe plus parity and framing error flags.

---
 rtl/uart_receiver_if.sv | 30 +++
 rtl/uart_receiver.sv | 150 +++++++++++++++
 tb/tb_uart_receiver.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_if.sv
// Receive-side bus of the UART receiver: tick/line inputs plus the recovered word and status.
// The receiver takes the master modport; whatever consumes the received words takes the slave modport.
interface uart_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_tick;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_dout;
    logic                 rx_done;
    logic                 parity_err;
    logic                 frame_err;

    modport master (
        input  rx_tick,
        input  rx,
        output rx_dout,
        output rx_done,
        output parity_err,
        output frame_err
    );

    modport slave (
        output rx_tick,
        output rx,
        input  rx_dout,
        input  rx_done,
        input  parity_err,
        input  frame_err
    );
endinterface

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: recovers LSB-first frames and reports each word with a one-cycle
// done strobe plus parity and framing error flags. It is frame-compatible with the team UART transmitter.
module uart_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int SB_TICKS   = 1,
    parameter int IS_PARITY  = 0,
    parameter int PARITY     = 0,
    parameter int OVERSAMPLE = 16
) (
    input  logic            clk,
    input  logic            reset,
    uart_receiver_if.master bus
);
    localparam int S_W = $clog2(OVERSAMPLE);
    localparam int N_W = $clog2(DATA_BITS);
    localparam logic [S_W-1:0] S_MID   = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_LAST  = S_W'(OVERSAMPLE - 1);
    localparam logic [N_W-1:0] N_LAST  = N_W'(DATA_BITS - 1);
    localparam logic           K_LAST  = 1'(SB_TICKS - 1);
    localparam logic           PAR_ODD = (PARITY != 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [S_W-1:0]       s;
    logic [N_W-1:0]       n;
    logic                 k;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 fe_sticky;
    logic [DATA_BITS-1:0] dout_q;
    logic                 done_q;
    logic                 perr_q;
    logic                 ferr_q;

    // Waiting half a bit in START puts every later sample at the centre of its bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            s         <= '0;
            n         <= '0;
            k         <= 1'b0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            fe_sticky <= 1'b0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
            done_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        s     <= '0;
                    end
                end
                ST_START: begin
                    if (bus.rx_tick) begin
                        if (s == S_MID) begin
                            if (!rx_s) begin
                                state     <= ST_DATA;
                                s         <= '0;
                                n         <= '0;
                                fe_sticky <= 1'b0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (bus.rx_tick) begin
                        if (s == S_LAST) begin
                            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                            s     <= '0;
                            if (n == N_LAST) begin
                                if (IS_PARITY != 0) begin
                                    state <= ST_PARITY;
                                end else begin
                                    state <= ST_STOP;
                                    k     <= 1'b0;
                                end
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bus.rx_tick) begin
                        if (s == S_LAST) begin
                            par_bit <= rx_s;
                            s       <= '0;
                            state   <= ST_STOP;
                            k       <= 1'b0;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (bus.rx_tick) begin
                        if (s == S_LAST) begin
                            s <= '0;
                            if (!rx_s) begin
                                fe_sticky <= 1'b1;
                            end
                            // Leaving mid-stop-bit lets IDLE catch a start edge that follows immediately.
                            if (k == K_LAST) begin
                                dout_q <= shreg;
                                perr_q <= (IS_PARITY != 0) && (par_bit != ((^shreg) ^ PAR_ODD));
                                ferr_q <= fe_sticky | ~rx_s;
                                done_q <= 1'b1;
                                state  <= ST_IDLE;
                            end else begin
                                k <= k + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rx_dout    = dout_q;
    assign bus.rx_done    = done_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: three instances (8N1, 8E1, 8N2) sharing one tick,
// each fed hand-built frames with its own serial line.
module tb_uart_receiver;
    logic clk;
    logic reset;
    logic tick;
    logic rxA;
    logic rxB;
    logic rxC;

    int nCompared;
    int nMismatched;
    int doneCnt [3];
    logic [7:0] lastDout [3];
    logic lastPe [3];
    logic lastFe [3];
    int expCnt [3];

    uart_receiver_if #(.DATA_BITS(8)) busA ();
    uart_receiver_if #(.DATA_BITS(8)) busB ();
    uart_receiver_if #(.DATA_BITS(8)) busC ();

    assign busA.rx_tick = tick;
    assign busB.rx_tick = tick;
    assign busC.rx_tick = tick;
    assign busA.rx = rxA;
    assign busB.rx = rxB;
    assign busC.rx = rxC;

    uart_receiver #(.DATA_BITS(8), .SB_TICKS(1), .IS_PARITY(0), .PARITY(0), .OVERSAMPLE(16)) dutA (
        .clk(clk), .reset(reset), .bus(busA)
    );
    uart_receiver #(.DATA_BITS(8), .SB_TICKS(1), .IS_PARITY(1), .PARITY(0), .OVERSAMPLE(16)) dutB (
        .clk(clk), .reset(reset), .bus(busB)
    );
    uart_receiver #(.DATA_BITS(8), .SB_TICKS(2), .IS_PARITY(0), .PARITY(0), .OVERSAMPLE(16)) dutC (
        .clk(clk), .reset(reset), .bus(busC)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One tick every 4 clk, so a bit period is 64 clk.
    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (busA.rx_done) begin
            doneCnt[0]++;
            lastDout[0] = busA.rx_dout;
            lastPe[0]   = busA.parity_err;
            lastFe[0]   = busA.frame_err;
        end
        if (busB.rx_done) begin
            doneCnt[1]++;
            lastDout[1] = busB.rx_dout;
            lastPe[1]   = busB.parity_err;
            lastFe[1]   = busB.frame_err;
        end
        if (busC.rx_done) begin
            doneCnt[2]++;
            lastDout[2] = busC.rx_dout;
            lastPe[2]   = busC.parity_err;
            lastFe[2]   = busC.frame_err;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic driveLine(input int which, input logic v, input int nclk);
        case (which)
            0:       rxA = v;
            1:       rxB = v;
            default: rxC = v;
        endcase
        repeat (nclk) @(posedge clk);
        #1;
    endtask

    // Each stop bit is held at its value for 48 clk then released high, which covers the
    // mid-bit sample while keeping a low stop bit from looking like the next start bit.
    task automatic applyStimulus(input int which, input logic [7:0] data, input logic parBit,
                                 input logic stop0, input logic stop1);
        driveLine(which, 1'b0, 64);
        for (int i = 0; i < 8; i++) begin
            driveLine(which, data[i], 64);
        end
        if (which == 1) begin
            driveLine(which, parBit, 64);
        end
        driveLine(which, stop0, 48);
        driveLine(which, 1'b1, 16);
        if (which == 2) begin
            driveLine(which, stop1, 48);
            driveLine(which, 1'b1, 16);
        end
    endtask

    task automatic checkFrame(input int which, input string tag, input logic [7:0] expDout,
                              input logic expPe, input logic expFe);
        expCnt[which]++;
        checkOutput({tag, " done count"}, doneCnt[which], expCnt[which]);
        checkOutput({tag, " rx_dout"}, lastDout[which], expDout);
        checkOutput({tag, " parity_err"}, lastPe[which], expPe);
        checkOutput({tag, " frame_err"}, lastFe[which], expFe);
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        for (int i = 0; i < 3; i++) begin
            doneCnt[i]  = 0;
            expCnt[i]   = 0;
            lastDout[i] = 8'h00;
            lastPe[i]   = 1'b0;
            lastFe[i]   = 1'b0;
        end
        reset = 1'b1;
        rxA   = 1'b1;
        rxB   = 1'b1;
        rxC   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset rx_dout", busA.rx_dout, 8'h00);
        checkOutput("reset rx_done", busA.rx_done, 1'b0);
        checkOutput("reset parity_err", busA.parity_err, 1'b0);
        checkOutput("reset frame_err", busA.frame_err, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        driveLine(0, 1'b1, 64);

        $display("[TB] 8N1 single frame");
        applyStimulus(0, 8'hA5, 1'b0, 1'b1, 1'b1);
        checkFrame(0, "A5", 8'hA5, 1'b0, 1'b0);

        $display("[TB] 8N1 back-to-back frames");
        applyStimulus(0, 8'h00, 1'b0, 1'b1, 1'b1);
        checkFrame(0, "b2b 00", 8'h00, 1'b0, 1'b0);
        applyStimulus(0, 8'hFF, 1'b0, 1'b1, 1'b1);
        checkFrame(0, "b2b FF", 8'hFF, 1'b0, 1'b0);
        applyStimulus(0, 8'h3C, 1'b0, 1'b1, 1'b1);
        checkFrame(0, "b2b 3C", 8'h3C, 1'b0, 1'b0);

        $display("[TB] framing error then clean frame");
        driveLine(0, 1'b1, 64);
        applyStimulus(0, 8'h55, 1'b0, 1'b0, 1'b1);
        checkFrame(0, "bad stop 55", 8'h55, 1'b0, 1'b1);
        driveLine(0, 1'b1, 128);
        applyStimulus(0, 8'h12, 1'b0, 1'b1, 1'b1);
        checkFrame(0, "clean 12", 8'h12, 1'b0, 1'b0);

        $display("[TB] short low glitch");
        driveLine(0, 1'b1, 64);
        driveLine(0, 1'b0, 16);
        driveLine(0, 1'b1, 200);
        checkOutput("glitch done count", doneCnt[0], expCnt[0]);
        checkOutput("glitch rx_dout", busA.rx_dout, 8'h12);
        checkOutput("glitch frame_err", busA.frame_err, 1'b0);

        $display("[TB] reset during data bits");
        driveLine(0, 1'b0, 64);
        driveLine(0, 1'b1, 64);
        driveLine(0, 1'b0, 64);
        driveLine(0, 1'b0, 32);
        reset = 1'b1;
        rxA   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("mid reset rx_dout", busA.rx_dout, 8'h00);
        checkOutput("mid reset rx_done", busA.rx_done, 1'b0);
        checkOutput("mid reset frame_err", busA.frame_err, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        driveLine(0, 1'b1, 200);
        checkOutput("aborted frame done count", doneCnt[0], expCnt[0]);
        applyStimulus(0, 8'h81, 1'b0, 1'b1, 1'b1);
        checkFrame(0, "after reset 81", 8'h81, 1'b0, 1'b0);

        $display("[TB] 8E1 parity");
        applyStimulus(1, 8'h07, 1'b1, 1'b1, 1'b1);
        checkFrame(1, "even par ok 07", 8'h07, 1'b0, 1'b0);
        driveLine(1, 1'b1, 64);
        applyStimulus(1, 8'h07, 1'b0, 1'b1, 1'b1);
        checkFrame(1, "even par bad 07", 8'h07, 1'b1, 1'b0);

        $display("[TB] 8N2 stop bits");
        applyStimulus(2, 8'h5A, 1'b0, 1'b1, 1'b1);
        checkFrame(2, "2 stop ok 5A", 8'h5A, 1'b0, 1'b0);
        driveLine(2, 1'b1, 64);
        applyStimulus(2, 8'hC3, 1'b0, 1'b1, 1'b0);
        checkFrame(2, "2nd stop bad C3", 8'hC3, 1'b0, 1'b1);

        driveLine(0, 1'b1, 64);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
